// File: rtl/alu_sched_pkg.sv
// Shared types, command constants and latency helper for the ALU request scheduler.
package alu_sched_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  localparam logic [3:0] CMD_MUL_INC = 4'd9;
  localparam logic [3:0] CMD_MUL_SHL = 4'd10;

  typedef struct packed {
    logic err;
    logic oflow;
    logic cout;
    logic g;
    logic l;
    logic e;
  } flags_t;

  // Multiply commands only exist in arithmetic mode; logic-mode 9/10 use the short path.
  function automatic int unsigned op_latency(input logic        mode,
                                             input logic [3:0]  cmd,
                                             input int unsigned alu_lat,
                                             input int unsigned mul_lat);
    if (mode && (cmd == CMD_MUL_INC || cmd == CMD_MUL_SHL)) return mul_lat;
    return alu_lat;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr, wrapping.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt_onehot,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               any
);

  logic [IDX_W-1:0] idx;

  assign any = |req;

  // Scan farthest-first so the candidate nearest to ptr is the last one written.
  always_comb begin
    gnt_idx = '0;
    idx     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ptr + IDX_W'(k);
      if (req[idx]) gnt_idx = idx;
    end
    gnt_onehot = any ? (NUM_REQ'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one ALU between NUM_REQ requesters, one operation at a time.
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int WIDTH   = 8,
  parameter  int CMD_W   = 4,
  parameter  int ALU_LAT = 1,
  parameter  int MUL_LAT = 2,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NUM_REQ-1:0]       REQ_VALID,
  output logic [NUM_REQ-1:0]       REQ_READY,
  input  logic [NUM_REQ-1:0]       REQ_MODE,
  input  logic [NUM_REQ*CMD_W-1:0] REQ_CMD,
  input  logic [NUM_REQ*WIDTH-1:0] REQ_OPA,
  input  logic [NUM_REQ*WIDTH-1:0] REQ_OPB,
  input  logic [NUM_REQ-1:0]       REQ_CIN,
  output logic                     ALU_CE,
  output logic [1:0]               ALU_INP_VALID,
  output logic                     ALU_MODE,
  output logic [CMD_W-1:0]         ALU_CMD,
  output logic [WIDTH-1:0]         ALU_OPA,
  output logic [WIDTH-1:0]         ALU_OPB,
  output logic                     ALU_CIN,
  input  logic [2*WIDTH-1:0]       ALU_RES,
  input  logic                     ALU_ERR,
  input  logic                     ALU_OFLOW,
  input  logic                     ALU_COUT,
  input  logic                     ALU_G,
  input  logic                     ALU_L,
  input  logic                     ALU_E,
  output logic                     RSP_VALID,
  input  logic                     RSP_READY,
  output logic [IDX_W-1:0]         RSP_ID,
  output logic [2*WIDTH-1:0]       RSP_RES,
  output logic [5:0]               RSP_FLAGS
);

  localparam int MAX_LAT = (ALU_LAT > MUL_LAT) ? ALU_LAT : MUL_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   gnt_q, gnt_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               mode_q, mode_d;
  logic [CMD_W-1:0]   cmd_q, cmd_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               cin_q, cin_d;
  logic [2*WIDTH-1:0] rsp_res_q, rsp_res_d;
  flags_t             rsp_flags_q, rsp_flags_d;

  logic [NUM_REQ-1:0] arb_onehot;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req        (REQ_VALID),
    .ptr        (rr_ptr_q),
    .gnt_onehot (arb_onehot),
    .gnt_idx    (arb_idx),
    .any        (arb_any)
  );

  always_ff @(posedge CLK) begin
    // NOTE: non-blocking so every register updates from the same pre-edge values.
    if (RST) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      gnt_q       <= '0;
      wait_cnt_q  <= '0;
      mode_q      <= 1'b0;
      cmd_q       <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      cin_q       <= 1'b0;
      rsp_res_q   <= '0;
      rsp_flags_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_q       <= gnt_d;
      wait_cnt_q  <= wait_cnt_d;
      mode_q      <= mode_d;
      cmd_q       <= cmd_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      cin_q       <= cin_d;
      rsp_res_q   <= rsp_res_d;
      rsp_flags_q <= rsp_flags_d;
    end
  end

  always_comb begin
    // NOTE: every _d takes its hold value first, so no path through the case infers a latch.
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_d       = gnt_q;
    wait_cnt_d  = wait_cnt_q;
    mode_d      = mode_q;
    cmd_d       = cmd_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    cin_d       = cin_q;
    rsp_res_d   = rsp_res_q;
    rsp_flags_d = rsp_flags_q;
    unique case (state_q)
      IDLE: if (arb_any) begin
        state_d = ISSUE;
        gnt_d   = arb_idx;
        mode_d  = REQ_MODE[arb_idx];
        cmd_d   = REQ_CMD[int'(arb_idx)*CMD_W +: CMD_W];
        opa_d   = REQ_OPA[int'(arb_idx)*WIDTH +: WIDTH];
        opb_d   = REQ_OPB[int'(arb_idx)*WIDTH +: WIDTH];
        cin_d   = REQ_CIN[arb_idx];
      end
      ISSUE: begin
        state_d    = WAIT;
        wait_cnt_d = CNT_W'(op_latency(mode_q, 4'(cmd_q), ALU_LAT, MUL_LAT));
      end
      WAIT: begin
        wait_cnt_d = wait_cnt_q - CNT_W'(1);
        if (wait_cnt_q == CNT_W'(1)) begin
          state_d     = RESP;
          rsp_res_d   = ALU_RES;
          rsp_flags_d = '{err: ALU_ERR, oflow: ALU_OFLOW, cout: ALU_COUT,
                          g: ALU_G, l: ALU_L, e: ALU_E};
        end
      end
      RESP: if (RSP_READY) begin
        state_d  = IDLE;
        rr_ptr_d = gnt_q + IDX_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset outranks a same-cycle grant, so the accept strobe is masked by RST.
  always_comb begin
    REQ_READY     = (state_q == IDLE && !RST) ? arb_onehot : '0;
    ALU_CE        = (state_q == ISSUE) || (state_q == WAIT);
    ALU_INP_VALID = ALU_CE ? 2'b11 : 2'b00;
    ALU_MODE      = mode_q;
    ALU_CMD       = cmd_q;
    ALU_OPA       = opa_q;
    ALU_OPB       = opb_q;
    ALU_CIN       = cin_q;
    RSP_VALID     = (state_q == RESP);
    RSP_ID        = gnt_q;
    RSP_RES       = rsp_res_q;
    RSP_FLAGS     = rsp_flags_q;
  end

endmodule

// File: tb/tb_alu_sched.sv
// Self-checking bench for alu_sched: directed sequences, a vector table and a randomized scoreboard.
module tb_alu_sched;

  localparam int N       = 4;
  localparam int W       = 8;
  localparam int CW      = 4;
  localparam int ALU_LAT = 1;
  localparam int MUL_LAT = 2;

  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic [N-1:0]   REQ_VALID, REQ_READY, REQ_MODE, REQ_CIN;
  logic [N*CW-1:0] REQ_CMD;
  logic [N*W-1:0] REQ_OPA, REQ_OPB;
  logic           ALU_CE, ALU_MODE, ALU_CIN;
  logic [1:0]     ALU_INP_VALID;
  logic [CW-1:0]  ALU_CMD;
  logic [W-1:0]   ALU_OPA, ALU_OPB;
  logic [2*W-1:0] ALU_RES;
  logic           ALU_ERR, ALU_OFLOW, ALU_COUT, ALU_G, ALU_L, ALU_E;
  logic           RSP_VALID, RSP_READY;
  logic [1:0]     RSP_ID;
  logic [2*W-1:0] RSP_RES;
  logic [5:0]     RSP_FLAGS;

  logic [CW-1:0]  r_cmd [N];
  logic [W-1:0]   r_a   [N];
  logic [W-1:0]   r_b   [N];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  alu_sched #(.NUM_REQ(N), .WIDTH(W), .CMD_W(CW), .ALU_LAT(ALU_LAT), .MUL_LAT(MUL_LAT)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_MODE(REQ_MODE),
    .REQ_CMD(REQ_CMD), .REQ_OPA(REQ_OPA), .REQ_OPB(REQ_OPB), .REQ_CIN(REQ_CIN),
    .ALU_CE(ALU_CE), .ALU_INP_VALID(ALU_INP_VALID), .ALU_MODE(ALU_MODE),
    .ALU_CMD(ALU_CMD), .ALU_OPA(ALU_OPA), .ALU_OPB(ALU_OPB), .ALU_CIN(ALU_CIN),
    .ALU_RES(ALU_RES), .ALU_ERR(ALU_ERR), .ALU_OFLOW(ALU_OFLOW), .ALU_COUT(ALU_COUT),
    .ALU_G(ALU_G), .ALU_L(ALU_L), .ALU_E(ALU_E),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_ID(RSP_ID),
    .RSP_RES(RSP_RES), .RSP_FLAGS(RSP_FLAGS)
  );

  always_comb begin
    for (int i = 0; i < N; i++) begin
      REQ_CMD[i*CW +: CW] = r_cmd[i];
      REQ_OPA[i*W +: W]   = r_a[i];
      REQ_OPB[i*W +: W]   = r_b[i];
    end
  end

  // Behavioural ALU: flags packed as {err, oflow, cout, g, l, e}.
  typedef struct packed {
    logic [15:0] res;
    logic [5:0]  flags;
  } alu_out_t;

  function automatic alu_out_t alu_ref(input logic mode, input logic [3:0] cmd,
                                       input logic [7:0] a, input logic [7:0] b, input logic cin);
    logic [15:0] r;
    logic err, of, co, g, l, e;
    r = '0; err = 0; of = 0; co = 0; g = 0; l = 0; e = 0;
    if (mode) begin
      case (cmd)
        4'd0:  begin r = 16'(a) + 16'(b); co = r[8]; end
        4'd1:  begin r = 16'(8'(a - b)); of = (a < b); end
        4'd2:  begin r = 16'(a) + 16'(b) + 16'(cin); co = r[8]; end
        4'd8:  begin g = (a > b); l = (a < b); e = (a == b); end
        4'd9:  r = (16'(a) + 16'd1) * (16'(b) + 16'd1);
        4'd10: r = 16'({a[6:0], 1'b0}) * 16'(b);
        default: err = 1'b1;
      endcase
    end else begin
      case (cmd)
        4'd0: r = {8'h00, a & b};
        4'd1: r = {8'h00, a | b};
        4'd2: r = {8'h00, a ^ b};
        default: err = 1'b1;
      endcase
    end
    return '{res: r, flags: {err, of, co, g, l, e}};
  endfunction

  function automatic int op_lat(input logic mode, input logic [3:0] cmd);
    return (mode && (cmd == 4'd9 || cmd == 4'd10)) ? MUL_LAT : ALU_LAT;
  endfunction

  // The ALU model only shows its real result once it has been enabled long enough.
  int       ce_cnt = 0;
  alu_out_t alu_o;
  always @(posedge CLK) ce_cnt <= ALU_CE ? ce_cnt + 1 : 0;
  always_comb begin
    alu_o = alu_ref(ALU_MODE, ALU_CMD, ALU_OPA, ALU_OPB, ALU_CIN);
    if (ce_cnt < op_lat(ALU_MODE, ALU_CMD)) alu_o = '{res: 16'hBEEF, flags: 6'b111111};
    ALU_RES = alu_o.res;
    {ALU_ERR, ALU_OFLOW, ALU_COUT, ALU_G, ALU_L, ALU_E} = alu_o.flags;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting on DUT (t=%0t)", name, $time);
  endtask

  task automatic set_req(input int i, input logic m, input logic [3:0] c,
                         input logic [7:0] a, input logic [7:0] b, input logic ci);
    REQ_MODE[i] = m;
    r_cmd[i]    = c;
    r_a[i]      = a;
    r_b[i]      = b;
    REQ_CIN[i]  = ci;
  endtask

  function automatic alu_out_t exp_for(input int i);
    return alu_ref(REQ_MODE[i], r_cmd[i], r_a[i], r_b[i], REQ_CIN[i]);
  endfunction

  function automatic int ready_idx();
    int id = -1;
    for (int i = 0; i < N; i++) if (REQ_READY[i]) id = i;
    return id;
  endfunction

  task automatic wait_grant(output int id);
    id = -1;
    for (int k = 0; k < 40 && id < 0; k++) begin
      @(negedge CLK);
      id = ready_idx();
    end
    if (id < 0) timeout_fail("grant");
  endtask

  // Counts cycles after the accept cycle until RSP_VALID is seen.
  task automatic wait_rsp(output int lat);
    lat = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(negedge CLK);
      if (RSP_VALID) lat = k;
    end
    if (lat == 0) timeout_fail("response");
  endtask

  typedef struct {
    int          id;
    logic        mode;
    logic [3:0]  cmd;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        cin;
    logic [15:0] res;
    logic [5:0]  flags;
    int          lat;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int       id, lat, g, mptr, acc_cyc, m_id, m_lat, phase;
    bit       busy;
    alu_out_t m_exp, e0;
    logic [N-1:0] exp_ready, granted;
    logic     exp_ce;

    tbl[0] = '{2, 1'b1, 4'd0,  8'd200, 8'd100, 1'b0, 16'd300,   6'b001000, 3};
    tbl[1] = '{0, 1'b1, 4'd9,  8'd3,   8'd4,   1'b0, 16'd20,    6'b000000, 4};
    tbl[2] = '{1, 1'b1, 4'd10, 8'd5,   8'd6,   1'b0, 16'd60,    6'b000000, 4};
    tbl[3] = '{3, 1'b1, 4'd1,  8'd5,   8'd9,   1'b0, 16'h00FC,  6'b010000, 3};
    tbl[4] = '{1, 1'b1, 4'd8,  8'd7,   8'd7,   1'b0, 16'd0,     6'b000001, 3};
    tbl[5] = '{0, 1'b0, 4'd9,  8'd3,   8'd4,   1'b0, 16'd0,     6'b100000, 3};
    tbl[6] = '{2, 1'b0, 4'd2,  8'hF0,  8'h3C,  1'b0, 16'h00CC,  6'b000000, 3};
    tbl[7] = '{3, 1'b1, 4'd2,  8'd255, 8'd255, 1'b1, 16'h01FF,  6'b001000, 3};
    tbl[8] = '{0, 1'b1, 4'd11, 8'd5,   8'd5,   1'b0, 16'd0,     6'b100000, 3};

    RSP_READY = 1'b0;
    REQ_VALID = '1;
    REQ_MODE  = '0;
    REQ_CIN   = '0;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 4'd0, 8'(10 * i + 1), 8'(i), 1'b0);

    // Reset held with every requester pending.
    repeat (2) begin
      @(negedge CLK);
      check("rst_req_ready", 32'(REQ_READY), 32'd0);
      check("rst_alu_ce", 32'(ALU_CE), 32'd0);
      check("rst_inp_valid", 32'(ALU_INP_VALID), 32'd0);
      check("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
      check("rst_rsp_fields", 32'({RSP_ID, RSP_FLAGS, RSP_RES}), 32'd0);
      check("rst_alu_pins", 32'({ALU_MODE, ALU_CMD, ALU_OPA, ALU_OPB, ALU_CIN}), 32'd0);
    end
    @(posedge CLK); #1;
    RST = 1'b0;
    RSP_READY = 1'b1;
    @(negedge CLK);
    check("rst_first_ready", 32'(REQ_READY), 32'b0001);

    // Fairness: all requesters pending, responses drained immediately.
    for (int k = 0; k < 6; k++) begin
      if (k > 0) wait_grant(id);
      else id = ready_idx();
      check("fair_order", 32'(id), 32'(k % N));
      wait_rsp(lat);
      check("fair_latency", 32'(lat), 32'd3);
      check("fair_rsp_id", 32'(RSP_ID), 32'(k % N));
      e0 = exp_for(k % N);
      check("fair_rsp_res", 32'(RSP_RES), 32'(e0.res));
    end

    // Backpressure on requester 2's response.
    @(posedge CLK); #1;
    RSP_READY = 1'b0;
    wait_grant(id);
    check("bp_grant", 32'(id), 32'd2);
    wait_rsp(lat);
    e0 = exp_for(2);
    for (int j = 0; j < 10; j++) begin
      check("bp_rsp_valid", 32'(RSP_VALID), 32'd1);
      check("bp_rsp_fields", 32'({RSP_ID, RSP_FLAGS, RSP_RES}), 32'({2'd2, e0.flags, e0.res}));
      check("bp_alu_ce", 32'(ALU_CE), 32'd0);
      check("bp_req_ready", 32'(REQ_READY), 32'd0);
      @(negedge CLK);
    end
    @(posedge CLK); #1;
    RSP_READY = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    check("bp_next_grant", 32'(REQ_READY), 32'b1000);
    wait_rsp(lat);
    check("bp_next_id", 32'(RSP_ID), 32'd3);

    // Lone requester with a multiply, aborted by reset during WAIT.
    @(posedge CLK); #1;
    REQ_VALID = 4'b0010;
    set_req(1, 1'b1, 4'd9, 8'd7, 8'd8, 1'b0);
    wait_grant(id);
    check("abort_grant", 32'(id), 32'd1);
    @(posedge CLK); #1;
    REQ_VALID = '0;
    @(negedge CLK);
    @(negedge CLK);
    check("abort_wait_ce", 32'(ALU_CE), 32'd1);
    @(posedge CLK); #1;
    RST = 1'b1;
    REQ_VALID = '1;
    @(negedge CLK);
    check("abort_rst_ready", 32'(REQ_READY), 32'd0);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    check("abort_rsp_valid", 32'(RSP_VALID), 32'd0);
    check("abort_alu_ce", 32'(ALU_CE), 32'd0);
    check("abort_alu_opa", 32'(ALU_OPA), 32'd0);
    check("abort_ptr_zero", 32'(REQ_READY), 32'b0001);
    @(posedge CLK); #1;
    REQ_VALID = '0;
    wait_rsp(lat);
    check("abort_next_lat", 32'(lat), 32'd3);
    check("abort_next_id", 32'(RSP_ID), 32'd0);
    e0 = exp_for(0);
    check("abort_next_res", 32'(RSP_RES), 32'(e0.res));

    // Vector table, one requester at a time.
    for (int v = 0; v < 9; v++) begin
      @(posedge CLK); #1;
      set_req(tbl[v].id, tbl[v].mode, tbl[v].cmd, tbl[v].a, tbl[v].b, tbl[v].cin);
      REQ_VALID = '0;
      REQ_VALID[tbl[v].id] = 1'b1;
      wait_grant(id);
      check("tbl_grant", 32'(id), 32'(tbl[v].id));
      @(posedge CLK); #1;
      REQ_VALID = '0;
      wait_rsp(lat);
      check("tbl_latency", 32'(lat), 32'(tbl[v].lat));
      check("tbl_rsp_id", 32'(RSP_ID), 32'(tbl[v].id));
      check("tbl_rsp_res", 32'(RSP_RES), 32'(tbl[v].res));
      check("tbl_rsp_flags", 32'(RSP_FLAGS), 32'(tbl[v].flags));
    end

    // Randomized traffic against a scoreboard of one outstanding op.
    mptr = (tbl[8].id + 1) % N;
    busy = 1'b0;
    acc_cyc = 0; m_id = 0; m_lat = 0;
    m_exp = '0;
    granted = '0;
    @(posedge CLK); #1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (granted[i]) begin
          REQ_VALID[i] = 1'b0;
          granted[i] = 1'b0;
        end else if (REQ_VALID[i] && $urandom_range(0, 31) == 0) begin
          REQ_VALID[i] = 1'b0;
        end else if (!REQ_VALID[i] && $urandom_range(0, 3) == 0) begin
          case ($urandom_range(0, 6))
            0: r_cmd[i] = 4'd0;
            1: r_cmd[i] = 4'd1;
            2: r_cmd[i] = 4'd2;
            3: r_cmd[i] = 4'd8;
            4: r_cmd[i] = 4'd9;
            5: r_cmd[i] = 4'd10;
            default: r_cmd[i] = 4'($urandom_range(0, 15));
          endcase
          REQ_MODE[i] = 1'($urandom_range(0, 1));
          REQ_CIN[i]  = 1'($urandom_range(0, 1));
          r_a[i] = 8'($urandom);
          r_b[i] = 8'($urandom);
          REQ_VALID[i] = 1'b1;
        end
      end
      RSP_READY = ($urandom_range(0, 2) != 0);

      @(negedge CLK);
      g = -1;
      exp_ready = '0;
      if (!busy) begin
        for (int k = 0; k < N; k++) begin
          if (g < 0 && REQ_VALID[(mptr + k) % N]) g = (mptr + k) % N;
        end
        if (g >= 0) exp_ready[g] = 1'b1;
      end
      check("rnd_req_ready", 32'(REQ_READY), 32'(exp_ready));
      phase  = cyc - acc_cyc;
      exp_ce = busy && phase >= 1 && phase <= m_lat - 1;
      check("rnd_alu_ce", 32'(ALU_CE), 32'(exp_ce));
      check("rnd_inp_valid", 32'(ALU_INP_VALID), exp_ce ? 32'd3 : 32'd0);
      check("rnd_rsp_valid", 32'(RSP_VALID), 32'(busy && phase >= m_lat));
      if (busy && phase >= m_lat && RSP_VALID) begin
        check("rnd_rsp_id", 32'(RSP_ID), 32'(m_id));
        check("rnd_rsp_res", 32'(RSP_RES), 32'(m_exp.res));
        check("rnd_rsp_flags", 32'(RSP_FLAGS), 32'(m_exp.flags));
        if (RSP_READY) begin
          busy = 1'b0;
          mptr = (m_id + 1) % N;
        end
      end else if (g >= 0) begin
        busy    = 1'b1;
        acc_cyc = cyc;
        m_id    = g;
        m_exp   = exp_for(g);
        m_lat   = op_lat(REQ_MODE[g], r_cmd[g]) + 2;
        granted[g] = 1'b1;
      end
      @(posedge CLK); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
